// File: rtl/io_pwr_pkg.sv
// Shared types and defaults for the IO pad-ring power sequencer family.
package io_pwr_pkg;
  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_ON       = 3'd3,
    ST_SHUTDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } pwr_st_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int SETTLE_CYC_DEF  = 8;
  localparam int GLITCH_W        = 8;
endpackage

// File: rtl/io_pwr_sync.sv
// Multi-flop synchronizer for asynchronous supply-detector flags; clears with reset.
module io_pwr_sync
  import io_pwr_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ff <= '0;
    else         ff <= {ff[STAGES-2:0], d_i};
  end

  assign q_o = ff[STAGES-1];
endmodule

// File: rtl/io_pwr_seq.sv
// IO ring power sequencer: debounce supply, release pads, then isolation, with fault latch.
// Optional glitch counter output under IO_PWR_SEQ_GLITCH_CNT_EN.
module io_pwr_seq
  import io_pwr_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_W       = 16,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pwr_ok_i,
  input  logic             en_i,
  input  logic [DEB_W-1:0] deb_cnt_i,
  input  logic             clr_fault_i,
  output logic             pad_en_o,
  output logic             iso_n_o,
  output logic             pwr_good_o,
  output logic             fault_o,
  output logic [2:0]       state_o
`ifdef IO_PWR_SEQ_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt_o
`endif
);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  pwr_st_e          st;
  logic             pok;
  logic [DEB_W-1:0] deb_cnt, deb_thr, deb_nxt;
  logic [7:0]       tmr;

  io_pwr_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pwr_ok_i),
    .q_o    (pok)
  );

  assign deb_thr = (deb_cnt_i == '0) ? DEB_W'(1) : deb_cnt_i;
  assign deb_nxt = (&deb_cnt) ? deb_cnt : deb_cnt + DEB_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st      <= ST_OFF;
      deb_cnt <= '0;
      tmr     <= '0;
    end else begin
      case (st)
        ST_OFF:
          if (en_i && pok) begin
            st      <= ST_DEBOUNCE;
            deb_cnt <= '0;
          end
        ST_DEBOUNCE:
          if (!pok || !en_i) st <= ST_OFF;
          else begin
            deb_cnt <= deb_nxt;
            // >= keeps a threshold lowered mid-debounce from stalling the FSM
            if (deb_nxt >= deb_thr) begin
              st  <= ST_RELEASE;
              tmr <= '0;
            end
          end
        ST_RELEASE:
          if (!pok)                    st  <= ST_FAULT;
          else if (tmr == SETTLE_LAST) st  <= ST_ON;
          else                         tmr <= tmr + 8'd1;
        ST_ON:
          if (!pok) st <= ST_FAULT;
          else if (!en_i) begin
            st  <= ST_SHUTDOWN;
            tmr <= '0;
          end
        ST_SHUTDOWN:
          if (!pok)                    st  <= ST_FAULT;
          else if (tmr == SETTLE_LAST) st  <= ST_OFF;
          else                         tmr <= tmr + 8'd1;
        ST_FAULT:
          if (clr_fault_i) st <= ST_OFF;
        default: st <= ST_OFF;
      endcase
    end
  end

`ifdef IO_PWR_SEQ_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          glitch_cnt <= '0;
    else if (clr_fault_i) glitch_cnt <= '0;
    else if (st == ST_DEBOUNCE && !pok && !(&glitch_cnt))
      glitch_cnt <= glitch_cnt + GLITCH_W'(1);
  end

  assign glitch_cnt_o = glitch_cnt;
`endif

  // Pure state decode: iso_n_o is only ever high in ON, where pad_en_o is high too.
  assign pad_en_o   = (st == ST_RELEASE) || (st == ST_ON) || (st == ST_SHUTDOWN);
  assign iso_n_o    = (st == ST_ON);
  assign pwr_good_o = (st == ST_ON);
  assign fault_o    = (st == ST_FAULT);
  assign state_o    = st;
endmodule
